// File: rtl/jtframe_mister_ctrl.sv
// MiSTer control glue: PLL supervisor, system/game reset stretchers,
// joystick/coin/start mapping to active-low, OSD DIP decode and pause toggle.
module jtframe_mister_ctrl #(
  parameter int unsigned THREE_BUTTONS = 1
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        pll_locked,
  output logic        pll_rst,
  input  logic        rst_req,
  input  logic [1:0]  buttons,
  input  logic        downloading,
  input  logic [31:0] status,
  input  logic [15:0] joy1_raw,
  input  logic [15:0] joy2_raw,
  output logic        rst,
  output logic        game_rst,
  output logic        game_rst_n,
  output logic [9:0]  game_joystick1,
  output logic [9:0]  game_joystick2,
  output logic [1:0]  game_coin,
  output logic [1:0]  game_start,
  output logic        enable_fm,
  output logic        enable_psg,
  output logic        dip_test,
  output logic        dip_flip,
  output logic        dip_pause,
  output logic [1:0]  dip_fxlevel,
  output logic        LED
);

  // Buttons 4-6 sit in bits 9:7; active-low, so forcing them released means 1.
  localparam logic [9:0] ForceMask = (THREE_BUTTONS != 0) ? 10'h380 : 10'h000;

  logic [7:0] rst_cnt;
  logic       last_locked;
  logic       req;
  logic       game_req;
  logic [3:0] sys_cnt_q, sys_cnt_d;
  logic [3:0] game_cnt_q, game_cnt_d;
  logic       rst_d;
  logic       game_rst_d;
  logic [9:0] joy1_map, joy2_map;
  logic       last_j1_q, last_j2_q;
  logic       pause_rise;
  logic       unused_bits;

  assign req        = rst_req | status[0] | buttons[1] | ~pll_locked;
  assign game_req   = req | downloading;
  assign game_rst_n = ~game_rst;
  assign joy1_map   = ~joy1_raw[9:0] | ForceMask;
  assign joy2_map   = ~joy2_raw[9:0] | ForceMask;
  assign pause_rise = (joy1_raw[15] & ~last_j1_q) | (joy2_raw[15] & ~last_j2_q);

  assign unused_bits = ^{status[31:13], status[9], status[5:1], joy1_raw[14:12],
                         joy2_raw[14:12], buttons[0]};

  // PLL supervisor: lock-loss edge reloads the countdown, pll_rst drops once it hits zero
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      last_locked <= 1'b0;
      rst_cnt     <= 8'hD0;
      pll_rst     <= 1'b0;
    end else begin
      last_locked <= pll_locked;
      if (last_locked && !pll_locked) begin
        rst_cnt <= 8'hFF;
        pll_rst <= 1'b1;
      end else if (rst_cnt != 8'd0) begin
        rst_cnt <= rst_cnt - 8'd1;
      end else begin
        pll_rst <= 1'b0;
      end
    end
  end

  // Reset stretchers: request reloads 15; reset clears once the count has reached zero
  always_comb begin
    sys_cnt_d  = sys_cnt_q;
    rst_d      = rst;
    game_cnt_d = game_cnt_q;
    game_rst_d = game_rst;
    if (req) begin
      sys_cnt_d = 4'd15;
      rst_d     = 1'b1;
    end else if (sys_cnt_q != 4'd0) begin
      sys_cnt_d = sys_cnt_q - 4'd1;
    end else begin
      rst_d = 1'b0;
    end
    if (game_req) begin
      game_cnt_d = 4'd15;
      game_rst_d = 1'b1;
    end else if (game_cnt_q != 4'd0) begin
      game_cnt_d = game_cnt_q - 4'd1;
    end else begin
      game_rst_d = 1'b0;
    end
  end

  // Reset stretcher state
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sys_cnt_q  <= 4'd15;
      rst        <= 1'b1;
      game_cnt_q <= 4'd15;
      game_rst   <= 1'b1;
    end else begin
      sys_cnt_q  <= sys_cnt_d;
      rst        <= rst_d;
      game_cnt_q <= game_cnt_d;
      game_rst   <= game_rst_d;
    end
  end

  // Player inputs; keyed on game_rst_d so outputs are idle in exactly the game_rst cycles
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      game_joystick1 <= 10'h3FF;
      game_joystick2 <= 10'h3FF;
      game_coin      <= 2'b11;
      game_start     <= 2'b11;
    end else if (game_rst_d) begin
      game_joystick1 <= 10'h3FF;
      game_joystick2 <= 10'h3FF;
      game_coin      <= 2'b11;
      game_start     <= 2'b11;
    end else begin
      game_joystick1 <= joy1_map;
      game_joystick2 <= joy2_map;
      game_coin      <= ~{joy2_raw[11], joy1_raw[11]};
      game_start     <= ~{joy2_raw[10], joy1_raw[10]};
    end
  end

  // DIP decode, pause toggle and download LED
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      enable_psg  <= 1'b1;
      enable_fm   <= 1'b1;
      dip_test    <= 1'b1;
      dip_flip    <= 1'b0;
      dip_fxlevel <= 2'b00;
      dip_pause   <= 1'b1;
      last_j1_q   <= 1'b0;
      last_j2_q   <= 1'b0;
      LED         <= 1'b0;
    end else begin
      enable_psg  <= ~status[7];
      enable_fm   <= ~status[8];
      dip_test    <= ~status[6];
      dip_flip    <= status[12];
      dip_fxlevel <= status[11:10];
      last_j1_q   <= joy1_raw[15];
      last_j2_q   <= joy2_raw[15];
      LED         <= downloading;
      if (game_rst_d) begin
        dip_pause <= 1'b1;
      end else if (pause_rise) begin
        dip_pause <= ~dip_pause;
      end
    end
  end

endmodule

// File: tb/tb_jtframe_mister_ctrl.sv
// Directed bench for jtframe_mister_ctrl: vector table plus reset/PLL sequences.
module tb_jtframe_mister_ctrl;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        pll_locked;
  logic        rst_req;
  logic [1:0]  buttons;
  logic        downloading;
  logic [31:0] status;
  logic [15:0] joy1_raw, joy2_raw;

  logic        pll_rst, rst, game_rst, game_rst_n;
  logic [9:0]  game_joystick1, game_joystick2;
  logic [1:0]  game_coin, game_start, dip_fxlevel;
  logic        enable_fm, enable_psg, dip_test, dip_flip, dip_pause, LED;

  logic        p0_pll_rst, p0_rst, p0_game_rst, p0_game_rst_n;
  logic [9:0]  p0_joy1, p0_joy2;
  logic [1:0]  p0_coin, p0_start, p0_fx;
  logic        p0_fm, p0_psg, p0_test, p0_flip, p0_pause, p0_led;

  int total = 0;
  int bad   = 0;

  always #5 clk_sys = ~clk_sys;

  jtframe_mister_ctrl dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .pll_locked(pll_locked), .pll_rst(pll_rst),
    .rst_req(rst_req), .buttons(buttons), .downloading(downloading), .status(status),
    .joy1_raw(joy1_raw), .joy2_raw(joy2_raw), .rst(rst), .game_rst(game_rst),
    .game_rst_n(game_rst_n), .game_joystick1(game_joystick1),
    .game_joystick2(game_joystick2), .game_coin(game_coin), .game_start(game_start),
    .enable_fm(enable_fm), .enable_psg(enable_psg), .dip_test(dip_test),
    .dip_flip(dip_flip), .dip_pause(dip_pause), .dip_fxlevel(dip_fxlevel), .LED(LED)
  );

  jtframe_mister_ctrl #(.THREE_BUTTONS(0)) dut0 (
    .clk_sys(clk_sys), .rst_n(rst_n), .pll_locked(pll_locked), .pll_rst(p0_pll_rst),
    .rst_req(rst_req), .buttons(buttons), .downloading(downloading), .status(status),
    .joy1_raw(joy1_raw), .joy2_raw(joy2_raw), .rst(p0_rst), .game_rst(p0_game_rst),
    .game_rst_n(p0_game_rst_n), .game_joystick1(p0_joy1), .game_joystick2(p0_joy2),
    .game_coin(p0_coin), .game_start(p0_start), .enable_fm(p0_fm), .enable_psg(p0_psg),
    .dip_test(p0_test), .dip_flip(p0_flip), .dip_pause(p0_pause), .dip_fxlevel(p0_fx),
    .LED(p0_led)
  );

  typedef struct {
    logic [31:0] st;
    logic [15:0] j1;
    logic [15:0] j2;
    logic        dl;
    logic [9:0]  e_j1;
    logic [9:0]  e_j2;
    logic [9:0]  e_p0_j1;
    logic [9:0]  e_p0_j2;
    logic [1:0]  e_start;
    logic [1:0]  e_coin;
    logic        e_psg;
    logic        e_fm;
    logic        e_test;
    logic        e_flip;
    logic [1:0]  e_fx;
    logic        e_led;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // Counts negedge samples while the selected signal stays high (bounded).
  task automatic count_high(input int sel, output int n);
    n = 0;
    while (((sel == 0) ? pll_rst : ((sel == 1) ? rst : game_rst)) && n < 600) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    int n;
    int ng;

    vecs[0] = '{32'h0, 16'h0000, 16'h0000, 1'b0, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF,
                2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0};
    vecs[1] = '{32'h1480, 16'h0FFF, 16'h0000, 1'b0, 10'h380, 10'h3FF, 10'h000, 10'h3FF,
                2'b10, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0};
    vecs[2] = '{32'h0D40, 16'h0005, 16'h0C0A, 1'b0, 10'h3FA, 10'h3F5, 10'h3FA, 10'h3F5,
                2'b01, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0};
    vecs[3] = '{32'h0, 16'h03F0, 16'h0030, 1'b0, 10'h38F, 10'h3CF, 10'h00F, 10'h3CF,
                2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0};
    vecs[4] = '{32'h0, 16'h0FFF, 16'h0000, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF,
                2'b11, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1};

    rst_n = 1'b0; pll_locked = 1'b1; rst_req = 1'b0; buttons = 2'b00;
    downloading = 1'b0; status = 32'h0; joy1_raw = 16'h0; joy2_raw = 16'h0;
    tick(3);

    // Reset values
    check("rst_pll_rst", pll_rst, 1'b0);
    check("rst_rst_cnt", dut.rst_cnt, 8'hD0);
    check("rst_rst", rst, 1'b1);
    check("rst_game_rst", game_rst, 1'b1);
    check("rst_game_rst_n", game_rst_n, 1'b0);
    check("rst_joy1", game_joystick1, 10'h3FF);
    check("rst_joy2", game_joystick2, 10'h3FF);
    check("rst_coin", game_coin, 2'b11);
    check("rst_start", game_start, 2'b11);
    check("rst_pause", dip_pause, 1'b1);
    check("rst_led", LED, 1'b0);
    check("rst_fm_psg", {enable_fm, enable_psg}, 2'b11);
    check("rst_test_flip_fx", {dip_test, dip_flip, dip_fxlevel}, 4'b1000);

    // Release: rst_cnt counts down from 0xD0, resets clear after 16 edges
    rst_n = 1'b1;
    tick(1);
    check("post_rst_cnt", dut.rst_cnt, 8'hCF);
    check("post_pll_rst", pll_rst, 1'b0);
    tick(14);
    check("post_rst_still", rst, 1'b1);
    tick(1);
    check("post_rst_clear", rst, 1'b0);
    check("post_game_rst_clear", game_rst, 1'b0);
    check("post_game_rst_n", game_rst_n, 1'b1);
    tick(200);
    check("cnt_reached_zero", dut.rst_cnt, 8'h00);
    check("cnt_zero_pll_rst", pll_rst, 1'b0);

    // Single lock loss: pll_rst for 256 cycles
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    check("lock_loss_load", dut.rst_cnt, 8'hFF);
    count_high(0, n);
    check("pll_rst_span", n, 256);

    // Second lock loss 100 cycles into the countdown reloads 0xFF
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(99);
    check("mid_countdown", dut.rst_cnt, 8'h9C);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    check("reload_cnt", dut.rst_cnt, 8'hFF);
    check("reload_pll_rst", pll_rst, 1'b1);
    count_high(0, n);
    check("reload_span", n, 256);
    check("rst_low_after_lock", rst, 1'b0);

    // status[0] pulse for 3 cycles
    status = 32'h1;
    tick(1);
    check("st0_rst", rst, 1'b1);
    check("st0_game_rst", game_rst, 1'b1);
    check("st0_game_rst_n", game_rst_n, 1'b0);
    tick(2);
    status = 32'h0;
    n = 0; ng = 0;
    while (rst && n < 100) begin
      if (game_rst) ng++;
      if (game_rst_n === game_rst) check("game_rst_n_mirror", game_rst_n, ~game_rst);
      tick(1);
      n++;
    end
    check("st0_rst_fall", n, 16);
    check("st0_game_rst_fall", ng, 16);
    check("st0_game_rst_low", game_rst, 1'b0);
    check("st0_game_rst_n_high", game_rst_n, 1'b1);

    // Download: game_rst for 50 + 16 cycles, rst untouched, LED lags by one
    downloading = 1'b1;
    tick(1);
    check("dl_led_on", LED, 1'b1);
    check("dl_game_rst", game_rst, 1'b1);
    check("dl_rst", rst, 1'b0);
    tick(49);
    check("dl_game_rst_hold", game_rst, 1'b1);
    check("dl_led_hold", LED, 1'b1);
    downloading = 1'b0;
    check("dl_led_lag", LED, 1'b1);
    tick(1);
    check("dl_led_off", LED, 1'b0);
    n = 1;
    while (game_rst && n < 100) begin
      tick(1);
      n++;
    end
    check("dl_game_rst_fall", n, 16);
    check("dl_rst_unaffected", rst, 1'b0);

    // Vector table: input mapping and DIP decode
    for (int i = 0; i < 5; i++) begin
      status = vecs[i].st; joy1_raw = vecs[i].j1; joy2_raw = vecs[i].j2;
      downloading = vecs[i].dl;
      tick(1);
      check($sformatf("v%0d_joy1", i), game_joystick1, vecs[i].e_j1);
      check($sformatf("v%0d_joy2", i), game_joystick2, vecs[i].e_j2);
      check($sformatf("v%0d_p0_joy1", i), p0_joy1, vecs[i].e_p0_j1);
      check($sformatf("v%0d_p0_joy2", i), p0_joy2, vecs[i].e_p0_j2);
      check($sformatf("v%0d_start", i), game_start, vecs[i].e_start);
      check($sformatf("v%0d_coin", i), game_coin, vecs[i].e_coin);
      check($sformatf("v%0d_psg", i), enable_psg, vecs[i].e_psg);
      check($sformatf("v%0d_fm", i), enable_fm, vecs[i].e_fm);
      check($sformatf("v%0d_test", i), dip_test, vecs[i].e_test);
      check($sformatf("v%0d_flip", i), dip_flip, vecs[i].e_flip);
      check($sformatf("v%0d_fx", i), dip_fxlevel, vecs[i].e_fx);
      check($sformatf("v%0d_led", i), LED, vecs[i].e_led);
    end
    downloading = 1'b0; status = 32'h0; joy1_raw = 16'h0; joy2_raw = 16'h0;
    tick(20);
    check("pre_pause_game_rst", game_rst, 1'b0);

    // Pause toggle on rising edges of bit 15, forced running by game reset
    check("pause_idle", dip_pause, 1'b1);
    joy1_raw = 16'h8000;
    tick(1);
    check("pause_toggle_0", dip_pause, 1'b0);
    tick(3);
    check("pause_level_hold", dip_pause, 1'b0);
    joy1_raw = 16'h0;
    tick(1);
    joy1_raw = 16'h8000;
    tick(1);
    check("pause_toggle_1", dip_pause, 1'b1);
    joy1_raw = 16'h0;
    joy2_raw = 16'h8000;
    tick(1);
    check("pause_joy2_toggle", dip_pause, 1'b0);
    joy2_raw = 16'h0;
    status = 32'h1;
    tick(1);
    check("pause_forced_by_reset", dip_pause, 1'b1);
    status = 32'h0;
    tick(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
